// File: rtl/branch_predictor_if.sv
// Fetch/resolve bundle between the core and the branch predictor.
// Lookup signals are combinational, update signals are sampled on the next clk edge.
// No backpressure: the predictor accepts one update every cycle.
interface branch_predictor_if #(
  parameter int PC_WIDTH   = 64,
  parameter int STAT_WIDTH = 32
);
  logic [PC_WIDTH-1:0]   lookup_pc;
  logic                  pred_valid;
  logic                  pred_taken;
  logic [PC_WIDTH-1:0]   pred_target;
  logic                  upd_valid;
  logic [PC_WIDTH-1:0]   upd_pc;
  logic                  upd_taken;
  logic [PC_WIDTH-1:0]   upd_target;
  logic                  upd_is_jump;
  logic                  upd_mispredict;
  logic [STAT_WIDTH-1:0] stat_updates;
  logic [STAT_WIDTH-1:0] stat_mispredicts;

  // Core side: drives fetch PC and resolved updates.
  modport master (
    output lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_is_jump, upd_mispredict,
    input  pred_valid, pred_taken, pred_target, stat_updates, stat_mispredicts
  );

  // Predictor side.
  modport slave (
    input  lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_is_jump, upd_mispredict,
    output pred_valid, pred_taken, pred_target, stat_updates, stat_mispredicts
  );
endinterface

// File: rtl/branch_predictor.sv
// Tagged direct-mapped BTB + saturating-counter PHT with hit/mispredict stats; optional gshare via BRANCH_PREDICTOR_GSHARE_EN.
// Latency: lookup is combinational (0 cycles); updates become visible to lookup the cycle after upd_valid.
// Backpressure: none; one update accepted per cycle, same-index lookup sees pre-update contents.
module branch_predictor #(
  parameter int PC_WIDTH   = 64,
  parameter int ENTRIES    = 64,
  parameter int TAG_WIDTH  = 8,
  parameter int CTR_WIDTH  = 2,
  parameter int GHR_WIDTH  = 6,
  parameter int STAT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  branch_predictor_if.slave    bp
);

  localparam int IDX    = $clog2(ENTRIES);
  localparam int TAG_LO = IDX + 2;
  localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
  localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;

  // BTB storage
  logic                 valid_q  [ENTRIES];
  logic                 valid_d  [ENTRIES];
  logic [TAG_WIDTH-1:0] tag_q    [ENTRIES];
  logic [TAG_WIDTH-1:0] tag_d    [ENTRIES];
  logic [PC_WIDTH-1:0]  target_q [ENTRIES];
  logic [PC_WIDTH-1:0]  target_d [ENTRIES];
  logic                 jump_q   [ENTRIES];
  logic                 jump_d   [ENTRIES];

  // PHT storage
  logic [CTR_WIDTH-1:0] pht_q    [ENTRIES];
  logic [CTR_WIDTH-1:0] pht_d    [ENTRIES];

  // Statistics
  logic [STAT_WIDTH-1:0] stat_upd_q, stat_upd_d;
  logic [STAT_WIDTH-1:0] stat_mis_q, stat_mis_d;

  // History folded to index width (zero in the plain bimodal build)
  logic [IDX-1:0] ghr_idx;

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  localparam int GW = (GHR_WIDTH < IDX) ? GHR_WIDTH : IDX;
  logic [GHR_WIDTH-1:0] ghr_q, ghr_d;
  assign ghr_idx = IDX'(ghr_q[GW-1:0]);
`else
  logic [GHR_WIDTH-1:0] unused_ghr;
  assign unused_ghr = '0;
  assign ghr_idx    = '0;
`endif

  // Only the index and tag fields of the PCs address the tables.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bp.lookup_pc, bp.upd_pc};

  logic [IDX-1:0]       l_bidx, l_pidx;
  logic [TAG_WIDTH-1:0] l_tag;
  logic                 l_hit, l_taken;

  // Same-cycle lookup: tag compare, direction from jump bit or PHT MSB
  always_comb begin
    l_bidx  = bp.lookup_pc[IDX+1:2];
    l_tag   = bp.lookup_pc[TAG_LO+TAG_WIDTH-1:TAG_LO];
    l_pidx  = l_bidx ^ ghr_idx;
    l_hit   = valid_q[l_bidx] && (tag_q[l_bidx] == l_tag);
    l_taken = l_hit && (jump_q[l_bidx] || pht_q[l_pidx][CTR_WIDTH-1]);
  end

  assign bp.pred_valid       = l_hit;
  assign bp.pred_taken       = l_taken;
  assign bp.pred_target      = l_taken ? target_q[l_bidx] : (bp.lookup_pc + PC_WIDTH'(4));
  assign bp.stat_updates     = stat_upd_q;
  assign bp.stat_mispredicts = stat_mis_q;

  logic [IDX-1:0]       u_bidx, u_pidx;
  logic [TAG_WIDTH-1:0] u_tag;

  // Next-state for tables, history and stats from the resolve-stage update
  always_comb begin
    valid_d    = valid_q;
    tag_d      = tag_q;
    target_d   = target_q;
    jump_d     = jump_q;
    pht_d      = pht_q;
    stat_upd_d = stat_upd_q;
    stat_mis_d = stat_mis_q;
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    ghr_d      = ghr_q;
`endif
    u_bidx = bp.upd_pc[IDX+1:2];
    u_tag  = bp.upd_pc[TAG_LO+TAG_WIDTH-1:TAG_LO];
    u_pidx = u_bidx ^ ghr_idx;

    if (bp.upd_valid) begin
      // Jumps carry their direction in the BTB, so they never train the PHT.
      if (!bp.upd_is_jump) begin
        if (bp.upd_taken) begin
          if (pht_q[u_pidx] != CTR_MAX) pht_d[u_pidx] = pht_q[u_pidx] + 1'b1;
        end else begin
          if (pht_q[u_pidx] != '0) pht_d[u_pidx] = pht_q[u_pidx] - 1'b1;
        end
`ifdef BRANCH_PREDICTOR_GSHARE_EN
        ghr_d = GHR_WIDTH'({ghr_q, bp.upd_taken});
`endif
      end

      // Taken: refresh a hit or (re)allocate over whatever aliases here.
      // Not-taken leaves the BTB alone either way.
      if (bp.upd_taken) begin
        valid_d[u_bidx]  = 1'b1;
        tag_d[u_bidx]    = u_tag;
        target_d[u_bidx] = bp.upd_target;
        jump_d[u_bidx]   = bp.upd_is_jump;
      end

      if (stat_upd_q != '1) stat_upd_d = stat_upd_q + 1'b1;
      if (bp.upd_mispredict && (stat_mis_q != '1)) stat_mis_d = stat_mis_q + 1'b1;
    end
  end

  // State registers; reset clears the BTB and returns counters to weakly-not-taken
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        jump_q[i]   <= 1'b0;
        pht_q[i]    <= CTR_INIT;
      end
      stat_upd_q <= '0;
      stat_mis_q <= '0;
`ifdef BRANCH_PREDICTOR_GSHARE_EN
      ghr_q      <= '0;
`endif
    end else begin
      valid_q    <= valid_d;
      tag_q      <= tag_d;
      target_q   <= target_d;
      jump_q     <= jump_d;
      pht_q      <= pht_d;
      stat_upd_q <= stat_upd_d;
      stat_mis_q <= stat_mis_d;
`ifdef BRANCH_PREDICTOR_GSHARE_EN
      ghr_q      <= ghr_d;
`endif
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (default build): lookup, PHT saturation, aliasing, no-bypass, stats.
// A second instance with STAT_WIDTH=2 shadows the same stimulus to exercise stat saturation.
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
module tb_branch_predictor;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  branch_predictor_if #(.PC_WIDTH(64), .STAT_WIDTH(32)) bus ();
  branch_predictor_if #(.PC_WIDTH(64), .STAT_WIDTH(2))  bus2 ();

  branch_predictor #(.STAT_WIDTH(32)) dut (.clk(clk), .rst(rst), .bp(bus.slave));
  branch_predictor #(.STAT_WIDTH(2))  dut2 (.clk(clk), .rst(rst), .bp(bus2.slave));

  assign bus2.lookup_pc      = bus.lookup_pc;
  assign bus2.upd_valid      = bus.upd_valid;
  assign bus2.upd_pc         = bus.upd_pc;
  assign bus2.upd_taken      = bus.upd_taken;
  assign bus2.upd_target     = bus.upd_target;
  assign bus2.upd_is_jump    = bus.upd_is_jump;
  assign bus2.upd_mispredict = bus.upd_mispredict;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One-cycle update pulse; returns just after the following falling edge.
  task automatic do_upd(input logic [63:0] pc, input logic taken, input logic [63:0] tgt,
                        input logic jmp, input logic misp);
    @(negedge clk);
    bus.upd_valid      = 1'b1;
    bus.upd_pc         = pc;
    bus.upd_taken      = taken;
    bus.upd_target     = tgt;
    bus.upd_is_jump    = jmp;
    bus.upd_mispredict = misp;
    @(negedge clk);
    bus.upd_valid      = 1'b0;
    bus.upd_mispredict = 1'b0;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.lookup_pc = 64'h100;
    #1;
    n_total++; if (bus.pred_valid !== 1'b0) $display("FAIL reset_pv got %0h want 0", bus.pred_valid); else n_pass++;
    n_total++; if (bus.pred_taken !== 1'b0) $display("FAIL reset_pt got %0h want 0", bus.pred_taken); else n_pass++;
    n_total++; if (bus.pred_target !== 64'h104) $display("FAIL reset_tgt got %0h want 104", bus.pred_target); else n_pass++;
    n_total++; if (bus.stat_updates !== 32'd0) $display("FAIL reset_su got %0d want 0", bus.stat_updates); else n_pass++;
    n_total++; if (bus.stat_mispredicts !== 32'd0) $display("FAIL reset_sm got %0d want 0", bus.stat_mispredicts); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // PHT 01 -> 10 after one taken update; entry allocated.
  task automatic test_taken_alloc();
    do_upd(64'h100, 1'b1, 64'h200, 1'b0, 1'b0);
    bus.lookup_pc = 64'h100;
    #1;
    n_total++; if (bus.pred_valid !== 1'b1) $display("FAIL alloc_pv got %0h want 1", bus.pred_valid); else n_pass++;
    n_total++; if (bus.pred_taken !== 1'b1) $display("FAIL alloc_pt got %0h want 1", bus.pred_taken); else n_pass++;
    n_total++; if (bus.pred_target !== 64'h200) $display("FAIL alloc_tgt got %0h want 200", bus.pred_target); else n_pass++;
    n_total++; if (bus.stat_updates !== 32'd1) $display("FAIL alloc_su got %0d want 1", bus.stat_updates); else n_pass++;
  endtask

  // 10 -> 01 -> 00, then a third not-taken must not wrap to 11.
  task automatic test_not_taken_sat();
    do_upd(64'h100, 1'b0, 64'h0, 1'b0, 1'b0);
    do_upd(64'h100, 1'b0, 64'h0, 1'b0, 1'b0);
    bus.lookup_pc = 64'h100;
    #1;
    n_total++; if (bus.pred_valid !== 1'b1) $display("FAIL nt_pv got %0h want 1", bus.pred_valid); else n_pass++;
    n_total++; if (bus.pred_taken !== 1'b0) $display("FAIL nt_pt got %0h want 0", bus.pred_taken); else n_pass++;
    n_total++; if (bus.pred_target !== 64'h104) $display("FAIL nt_tgt got %0h want 104", bus.pred_target); else n_pass++;
    do_upd(64'h100, 1'b0, 64'h0, 1'b0, 1'b0);
    #1;
    n_total++; if (bus.pred_valid !== 1'b1) $display("FAIL ntsat_pv got %0h want 1", bus.pred_valid); else n_pass++;
    n_total++; if (bus.pred_taken !== 1'b0) $display("FAIL ntsat_pt got %0h want 0", bus.pred_taken); else n_pass++;
    n_total++; if (bus.stat_updates !== 32'd4) $display("FAIL ntsat_su got %0d want 4", bus.stat_updates); else n_pass++;
  endtask

  // Jump on 0x200 evicts 0x100 (same bidx), predicts taken, leaves PHT[0] at 00.
  task automatic test_jump_alias();
    do_upd(64'h200, 1'b1, 64'h80, 1'b1, 1'b0);
    bus.lookup_pc = 64'h200;
    #1;
    n_total++; if (bus.pred_valid !== 1'b1) $display("FAIL jmp_pv got %0h want 1", bus.pred_valid); else n_pass++;
    n_total++; if (bus.pred_taken !== 1'b1) $display("FAIL jmp_pt got %0h want 1", bus.pred_taken); else n_pass++;
    n_total++; if (bus.pred_target !== 64'h80) $display("FAIL jmp_tgt got %0h want 80", bus.pred_target); else n_pass++;
    bus.lookup_pc = 64'h100;
    #1;
    n_total++; if (bus.pred_valid !== 1'b0) $display("FAIL alias_pv got %0h want 0", bus.pred_valid); else n_pass++;
    n_total++; if (bus.pred_taken !== 1'b0) $display("FAIL alias_pt got %0h want 0", bus.pred_taken); else n_pass++;
    n_total++; if (bus.pred_target !== 64'h104) $display("FAIL alias_tgt got %0h want 104", bus.pred_target); else n_pass++;
    // PHT[0] was 00; one taken cond update gives 01 (not taken) only if the jump left it alone.
    do_upd(64'h100, 1'b1, 64'h300, 1'b0, 1'b0);
    #1;
    n_total++; if (bus.pred_valid !== 1'b1) $display("FAIL phtkeep_pv got %0h want 1", bus.pred_valid); else n_pass++;
    n_total++; if (bus.pred_taken !== 1'b0) $display("FAIL phtkeep_pt got %0h want 0", bus.pred_taken); else n_pass++;
  endtask

  // Lookup and update of the same index in one cycle: no bypass.
  task automatic test_same_cycle();
    @(negedge clk);
    bus.lookup_pc   = 64'h40;
    bus.upd_valid   = 1'b1;
    bus.upd_pc      = 64'h40;
    bus.upd_taken   = 1'b1;
    bus.upd_target  = 64'h400;
    bus.upd_is_jump = 1'b0;
    #1;
    n_total++; if (bus.pred_valid !== 1'b0) $display("FAIL same_pv got %0h want 0", bus.pred_valid); else n_pass++;
    n_total++; if (bus.pred_target !== 64'h44) $display("FAIL same_tgt got %0h want 44", bus.pred_target); else n_pass++;
    @(negedge clk);
    bus.upd_valid = 1'b0;
    #1;
    n_total++; if (bus.pred_valid !== 1'b1) $display("FAIL next_pv got %0h want 1", bus.pred_valid); else n_pass++;
    n_total++; if (bus.pred_taken !== 1'b1) $display("FAIL next_pt got %0h want 1", bus.pred_taken); else n_pass++;
    n_total++; if (bus.pred_target !== 64'h400) $display("FAIL next_tgt got %0h want 400", bus.pred_target); else n_pass++;
  endtask

  // Five back-to-back updates, mispredict on three; 2-bit stats saturate at 3.
  task automatic test_back_to_back_stats();
    reset_pulse();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.upd_valid      = 1'b1;
      bus.upd_pc         = 64'h1000 + 64'(i * 4);
      bus.upd_taken      = (i % 2) == 1;
      bus.upd_target     = 64'h2000;
      bus.upd_is_jump    = 1'b0;
      bus.upd_mispredict = (i % 2) == 0;
    end
    @(negedge clk);
    bus.upd_valid      = 1'b0;
    bus.upd_mispredict = 1'b0;
    #1;
    n_total++; if (bus.stat_updates !== 32'd5) $display("FAIL stat_su got %0d want 5", bus.stat_updates); else n_pass++;
    n_total++; if (bus.stat_mispredicts !== 32'd3) $display("FAIL stat_sm got %0d want 3", bus.stat_mispredicts); else n_pass++;
    n_total++; if (bus2.stat_updates !== 2'd3) $display("FAIL sat_su got %0d want 3", bus2.stat_updates); else n_pass++;
    n_total++; if (bus2.stat_mispredicts !== 2'd3) $display("FAIL sat_sm got %0d want 3", bus2.stat_mispredicts); else n_pass++;
    bus.lookup_pc = 64'h1004;
    #1;
    n_total++; if (bus.pred_target !== 64'h2000) $display("FAIL b2b_tgt got %0h want 2000", bus.pred_target); else n_pass++;
  endtask

  // Reset asserted while an update is in flight: immediate effect, update dropped.
  task automatic test_reset_midrun();
    do_upd(64'h100, 1'b1, 64'h200, 1'b0, 1'b1);
    bus.lookup_pc = 64'h100;
    #1;
    n_total++; if (bus.pred_valid !== 1'b1) $display("FAIL pre_rst_pv got %0h want 1", bus.pred_valid); else n_pass++;
    bus.upd_valid      = 1'b1;
    bus.upd_pc         = 64'h104;
    bus.upd_taken      = 1'b1;
    bus.upd_target     = 64'h500;
    bus.upd_is_jump    = 1'b0;
    bus.upd_mispredict = 1'b1;
    rst = 1'b0;
    #1;
    n_total++; if (bus.pred_valid !== 1'b0) $display("FAIL mid_rst_pv got %0h want 0", bus.pred_valid); else n_pass++;
    n_total++; if (bus.pred_taken !== 1'b0) $display("FAIL mid_rst_pt got %0h want 0", bus.pred_taken); else n_pass++;
    n_total++; if (bus.pred_target !== 64'h104) $display("FAIL mid_rst_tgt got %0h want 104", bus.pred_target); else n_pass++;
    n_total++; if (bus.stat_updates !== 32'd0) $display("FAIL mid_rst_su got %0d want 0", bus.stat_updates); else n_pass++;
    @(negedge clk);
    rst                = 1'b1;
    bus.upd_valid      = 1'b0;
    bus.upd_mispredict = 1'b0;
    bus.lookup_pc      = 64'h104;
    #1;
    n_total++; if (bus.pred_valid !== 1'b0) $display("FAIL killed_pv got %0h want 0", bus.pred_valid); else n_pass++;
    n_total++; if (bus.pred_target !== 64'h108) $display("FAIL killed_tgt got %0h want 108", bus.pred_target); else n_pass++;
    n_total++; if (bus.stat_mispredicts !== 32'd0) $display("FAIL killed_sm got %0d want 0", bus.stat_mispredicts); else n_pass++;
  endtask

  initial begin
    n_pass             = 0;
    n_total            = 0;
    rst                = 1'b0;
    bus.lookup_pc      = '0;
    bus.upd_valid      = 1'b0;
    bus.upd_pc         = '0;
    bus.upd_taken      = 1'b0;
    bus.upd_target     = '0;
    bus.upd_is_jump    = 1'b0;
    bus.upd_mispredict = 1'b0;
    test_reset();
    test_taken_alloc();
    test_not_taken_sat();
    test_jump_alias();
    test_same_cycle();
    test_back_to_back_stats();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
